gpio_debounce_events: RTL and testbench



---
 rtl/gpio_debounce_channel.sv | 135 +++++++++++++
 rtl/gpio_debounce_events.sv | 85 ++++++++
 tb/tb_gpio_debounce_events.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_debounce_channel.sv
// gpio_debounce_channel
// ---------------------
// One debounced GPIO channel: synchroniser, sample history, accepted level,
// and the long-press counter with its event pulse. The sample strobe comes
// from a prescaler that all channels share in the parent.
//
// Ports:
//   clk         in  1  core clock
//   reset_n     in  1  asynchronous, active-low reset
//   sample_en   in  1  shared sample strobe (one cycle every RATE cycles)
//   pin         in  1  raw asynchronous pin level
//   level       out 1  debounced level (registered)
//   rise        out 1  one-cycle pulse when level goes 0->1
//   fall        out 1  one-cycle pulse when level goes 1->0
//   long_press  out 1  one-cycle pulse LONG_TICKS samples after rise

module gpio_debounce_channel #(
    parameter int N_SYNC     = 2,
    parameter int N          = 4,
    parameter int LONG_TICKS = 500
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_en,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int             LP_W    = $clog2(LONG_TICKS + 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_TICKS);
    localparam logic [LP_W-1:0] LP_PRE  = LP_W'(LONG_TICKS - 1);
    localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);
    localparam logic [LP_W-1:0] LP_ZERO = {LP_W{1'b0}};

    (* ASYNC_REG = "TRUE" *) logic [N_SYNC-1:0] sync_r;
    logic            sync_s;
    logic [N-1:0]    hist_r;
    logic [N-1:0]    hist_shift_s;
    logic [N-1:0]    hist_next_s;
    logic            all_one_s;
    logic            all_zero_s;
    logic            level_r;
    logic            level_next_s;
    logic            rise_r;
    logic            rise_next_s;
    logic            fall_r;
    logic            fall_next_s;
    logic            lp_r;
    logic            lp_next_s;
    logic [LP_W-1:0] cnt_r;
    logic [LP_W-1:0] cnt_next_s;

    assign sync_s = sync_r[N_SYNC-1];

    // History after this tick's shift; a one-deep history is just the sample.
    generate
        if (N == 1) begin : g_hist_one
            assign hist_shift_s = sync_s;
        end else begin : g_hist_many
            assign hist_shift_s = {hist_r[N-2:0], sync_s};
        end
    endgenerate

    assign all_one_s  = &hist_shift_s;
    assign all_zero_s = ~|hist_shift_s;

    // Synchroniser chain: metastability settles before the last stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {N_SYNC{1'b0}};
        end else begin
            sync_r <= {sync_r[N_SYNC-2:0], pin};
        end
    end

    // Next-state for history, level, events and long-press counter.
    always_comb begin
        hist_next_s  = hist_r;
        level_next_s = level_r;
        rise_next_s  = 1'b0;
        fall_next_s  = 1'b0;
        lp_next_s    = 1'b0;
        cnt_next_s   = cnt_r;
        if (sample_en) begin
            hist_next_s = hist_shift_s;
            if (all_one_s && !level_r) begin
                level_next_s = 1'b1;
                rise_next_s  = 1'b1;
                cnt_next_s   = LP_ZERO;
            end else if (all_zero_s && level_r) begin
                // A release clears the counter, re-arming the next press.
                level_next_s = 1'b0;
                fall_next_s  = 1'b1;
                cnt_next_s   = LP_ZERO;
            end else if (level_r && (cnt_r != LP_MAX)) begin
                // Saturating count; the pulse marks the step onto LONG_TICKS,
                // so it fires once per press.
                cnt_next_s = cnt_r + LP_ONE;
                lp_next_s  = (cnt_r == LP_PRE);
            end else begin
                cnt_next_s = cnt_r;
            end
        end else begin
            hist_next_s = hist_r;
        end
    end

    // Registered channel state and event outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_r  <= {N{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            lp_r    <= 1'b0;
            cnt_r   <= LP_ZERO;
        end else begin
            hist_r  <= hist_next_s;
            level_r <= level_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
            lp_r    <= lp_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign level      = level_r;
    assign rise       = rise_r;
    assign fall       = fall_r;
    assign long_press = lp_r;

endmodule

// File: rtl/gpio_debounce_events.sv
// gpio_debounce_events
// --------------------
// Multi-channel debouncer between raw GPIO pins and the core logic. A single
// prescaler produces the sample strobe; each channel debounces on it and
// emits rise / fall / long-press pulses independently.
//
// Ports:
//   clk         in  1      core clock
//   reset_n     in  1      asynchronous, active-low reset
//   in          in  WIDTH  raw asynchronous pin levels
//   out         out WIDTH  debounced levels
//   rise        out WIDTH  one-cycle pulse per channel on 0->1
//   fall        out WIDTH  one-cycle pulse per channel on 1->0
//   long_press  out WIDTH  one-cycle pulse, at most once per press
//   tick        out 1      sample strobe, one cycle every RATE cycles

module gpio_debounce_events #(
    parameter int WIDTH      = 8,
    parameter int N_SYNC     = 2,
    parameter int RATE       = 125000,
    parameter int N          = 4,
    parameter int LONG_TICKS = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] long_press,
    output logic             tick
);

    localparam int              CNT_W   = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] presc_r;
    logic [CNT_W-1:0] presc_next_s;
    logic             tick_r;

    // Prescaler wrap at RATE-1.
    always_comb begin
        presc_next_s = presc_r;
        if (presc_r == CNT_MAX) begin
            presc_next_s = {CNT_W{1'b0}};
        end else begin
            presc_next_s = presc_r + CNT_ONE;
        end
    end

    // Prescaler and strobe register; tick is high while the count sits at
    // RATE-1, and stays low through reset even when RATE is 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= {CNT_W{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            presc_r <= presc_next_s;
            tick_r  <= (presc_next_s == CNT_MAX);
        end
    end

    assign tick = tick_r;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            gpio_debounce_channel #(
                .N_SYNC     (N_SYNC),
                .N          (N),
                .LONG_TICKS (LONG_TICKS)
            ) u_ch (
                .clk        (clk),
                .reset_n    (reset_n),
                .sample_en  (tick_r),
                .pin        (in[i]),
                .level      (out[i]),
                .rise       (rise[i]),
                .fall       (fall[i]),
                .long_press (long_press[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gpio_debounce_events.sv
// Testbench for gpio_debounce_events: directed scenarios plus random pin
// activity, every cycle compared against a behavioural model built from the
// debounce rules (delayed samples, sample counts, cycle distances).

module tb_gpio_debounce_events;

    localparam int WIDTH      = 2;
    localparam int N_SYNC     = 2;
    localparam int RATE       = 4;
    localparam int N          = 4;
    localparam int LONG_TICKS = 8;
    localparam int LAT_MIN    = N_SYNC + (N - 1) * RATE + 1;
    localparam int LAT_MAX    = N_SYNC + N * RATE;
    localparam int LP_DELAY   = LONG_TICKS * RATE;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] pin = '0;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] lp;
    logic             tick;

    always #5 clk = ~clk;

    gpio_debounce_events #(
        .WIDTH(WIDTH), .N_SYNC(N_SYNC), .RATE(RATE), .N(N), .LONG_TICKS(LONG_TICKS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in(pin), .out(dout),
        .rise(rise), .fall(fall), .long_press(lp), .tick(tick)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_j;                 // clock edges since reset release
    logic [WIDTH-1:0] m_delay_q[$];        // pin values still in flight through the synchroniser
    int               m_hist[WIDTH][$];    // most recent samples, newest last
    logic [WIDTH-1:0] m_lvl;
    int               m_rise_j[WIDTH];
    bit               m_fired[WIDTH];
    logic [WIDTH-1:0] e_rise, e_fall, e_lp;
    logic             e_tick;

    task automatic model_reset();
        m_j = 0;
        m_delay_q.delete();
        for (int k = 0; k < N_SYNC; k++) m_delay_q.push_back('0);
        for (int c = 0; c < WIDTH; c++) begin
            m_hist[c].delete();
            for (int k = 0; k < N; k++) m_hist[c].push_back(0);
            m_rise_j[c] = 0;
            m_fired[c]  = 1'b0;
        end
        m_lvl  = '0;
        e_rise = '0;
        e_fall = '0;
        e_lp   = '0;
        e_tick = 1'b0;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] s;
        int ones;
        if (!reset_n) begin
            model_reset();
        end else begin
            m_j++;
            // Counter reaches RATE-1 after RATE-1 edges, then every RATE edges;
            // the sampling edge is the one following each such cycle.
            e_tick = ((m_j % RATE) == RATE - 1);
            s = m_delay_q.pop_front();
            m_delay_q.push_back(pin);
            e_rise = '0;
            e_fall = '0;
            e_lp   = '0;
            if ((m_j % RATE) == 0) begin
                for (int c = 0; c < WIDTH; c++) begin
                    void'(m_hist[c].pop_front());
                    m_hist[c].push_back(int'(s[c]));
                    ones = 0;
                    foreach (m_hist[c][k]) ones += m_hist[c][k];
                    if (ones == N && !m_lvl[c]) begin
                        m_lvl[c]    = 1'b1;
                        e_rise[c]   = 1'b1;
                        m_rise_j[c] = m_j;
                        m_fired[c]  = 1'b0;
                    end else if (ones == 0 && m_lvl[c]) begin
                        m_lvl[c]  = 1'b0;
                        e_fall[c] = 1'b1;
                    end
                end
            end
            for (int c = 0; c < WIDTH; c++) begin
                if (m_lvl[c] && !m_fired[c] && m_j == m_rise_j[c] + LP_DELAY) begin
                    e_lp[c]    = 1'b1;
                    m_fired[c] = 1'b1;
                end
            end
        end
    endtask

    // One clock: advance the model at the edge, compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("out", 32'(dout), 32'(m_lvl));
        check("rise", 32'(rise), 32'(e_rise));
        check("fall", 32'(fall), 32'(e_fall));
        check("long_press", 32'(lp), 32'(e_lp));
        check("tick", 32'(tick), 32'(e_tick));
    endtask

    // kind: 0 rise, 1 fall, 2 long_press. n = cycles until seen, -1 on timeout.
    task automatic wait_event(input int kind, input int ch, input int limit, output int n);
        logic [WIDTH-1:0] v;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            cycle();
            v = (kind == 0) ? rise : (kind == 1) ? fall : lp;
            if (v[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int kind, input int ch, input int len, output int cnt);
        logic [WIDTH-1:0] v;
        cnt = 0;
        for (int i = 0; i < len; i++) begin
            cycle();
            v = (kind == 0) ? rise : (kind == 1) ? fall : lp;
            if (v[ch]) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int first;
        int hold;
        model_reset();

        // Reset held with both pins high: everything stays 0.
        pin = 2'b11;
        reset_n = 1'b0;
        repeat (50) cycle();
        pin = 2'b00;
        reset_n = 1'b1;

        // First strobe: counter starts at 0, reaches RATE-1 after RATE-1 edges.
        first = -1;
        for (int i = 1; i <= 2 * RATE; i++) begin
            cycle();
            if (tick && first < 0) first = i;
        end
        check("first_tick_edge", 32'(first), 32'(RATE - 1));

        // Clean press on ch0.
        pin[0] = 1'b1;
        wait_event(0, 0, LAT_MAX + 10, n);
        check("press_latency_window", 32'(n >= LAT_MIN && n <= LAT_MAX), 32'd1);

        // Long press: exactly LONG_TICKS*RATE cycles after the rise pulse.
        wait_event(2, 0, LP_DELAY + 10, n);
        check("long_press_delay", 32'(n), 32'(LP_DELAY));
        count_pulses(2, 0, 200, c);
        check("long_press_no_repeat", 32'(c), 32'd0);
        pin[0] = 1'b0;
        wait_event(1, 0, LAT_MAX + 10, n);
        check("release_fall_seen", 32'(n > 0), 32'd1);

        // Re-press re-arms the long press.
        pin[0] = 1'b1;
        wait_event(0, 0, LAT_MAX + 10, n);
        check("repress_rise_seen", 32'(n > 0), 32'd1);
        wait_event(2, 0, LP_DELAY + 10, n);
        check("long_press_rearmed", 32'(n), 32'(LP_DELAY));
        pin[0] = 1'b0;
        wait_event(1, 0, LAT_MAX + 10, n);
        check("release2_fall_seen", 32'(n > 0), 32'd1);

        // Short press: released early enough that out drops (at most LAT_MAX
        // cycles later) before the LONG_TICKS*RATE mark.
        pin[0] = 1'b1;
        wait_event(0, 0, LAT_MAX + 10, n);
        check("short_rise_seen", 32'(n > 0), 32'd1);
        count_pulses(2, 0, LP_DELAY - LAT_MAX - 1, c);
        pin[0] = 1'b0;
        count_pulses(2, 0, 60, n);
        check("short_press_no_lp", 32'(c + n), 32'd0);

        // Glitch on ch1: 12 cycles high covers only 3 samples.
        pin[1] = 1'b1;
        repeat (3 * RATE) cycle();
        pin[1] = 1'b0;
        count_pulses(0, 1, 40, c);
        check("glitch_no_rise", 32'(c), 32'd0);
        check("glitch_out_low", 32'(dout[1]), 32'd0);

        // Async reset mid-press.
        pin[0] = 1'b1;
        wait_event(0, 0, LAT_MAX + 10, n);
        repeat (3) cycle();
        check("pre_reset_out_high", 32'(dout[0]), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_out", 32'(dout[0]), 32'd0);
        check("async_reset_all", 32'({dout, rise, fall, lp, tick}), 32'd0);
        pin[0] = 1'b0;
        repeat (5) cycle();
        reset_n = 1'b1;
        count_pulses(1, 0, 40, c);
        check("no_fall_after_reset", 32'(c), 32'd0);
        pin[0] = 1'b1;
        wait_event(0, 0, LAT_MAX + 10, n);
        check("post_reset_latency_window", 32'(n >= LAT_MIN && n <= LAT_MAX), 32'd1);
        repeat (5) cycle();

        // Simultaneous release of ch0 and press of ch1.
        pin = 2'b10;
        wait_event(1, 0, LAT_MAX + 10, n);
        check("simul_fall0_seen", 32'(n > 0), 32'd1);
        check("simul_rise1_same_cycle", 32'(rise[1]), 32'd1);

        // Random pin activity, model-checked every cycle.
        for (int it = 0; it < 150; it++) begin
            pin  = WIDTH'($urandom_range(0, 3));
            hold = $urandom_range(1, 40);
            if ($urandom_range(0, 4) == 0) hold += 40;
            repeat (hold) cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
